// File: rtl/seg_scan_controller_if.sv
// Bus between the digit source and seg_scan_controller: packed digits and controls
// in, anode/nibble/frame-sync out.
interface seg_scan_controller_if;
  logic [31:0] digits;
  logic        load;
  logic [7:0]  en_mask;
  logic        lz_blank;
  logic [7:0]  an;
  logic [3:0]  bcd;
  logic        frame_start;

  modport master (
    output digits, load, en_mask, lz_blank,
    input  an, bcd, frame_start
  );

  modport slave (
    input  digits, load, en_mask, lz_blank,
    output an, bcd, frame_start
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan of eight packed BCD digits onto a common-anode display, with
// inter-digit blanking, masking, leading-zero suppression and frame-synchronous updates.
module seg_scan_controller #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 17
) (
  input logic                 clk,
  input logic                 rst_n,
  seg_scan_controller_if.slave bus
);

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  localparam logic [CNT_W-1:0] ShowLast  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BlankLast = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      active_q, active_d;
  logic [31:0]      pending_q, pending_d;
  logic             pend_valid_q, pend_valid_d;
  logic [7:0]       an_q, an_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             frame_start_q, frame_start_d;

  logic             phase_done;
  logic             swap;
  logic [4:0]       shift;
  logic [3:0]       digit_nib;
  logic             upper_zero;
  logic             suppress;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBlank;
      idx_q         <= 3'd0;
      cnt_q         <= '0;
      active_q      <= 32'h0;
      pending_q     <= 32'h0;
      pend_valid_q  <= 1'b0;
      an_q          <= 8'hFF;
      bcd_q         <= 4'hF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      pend_valid_q  <= pend_valid_d;
      an_q          <= an_d;
      bcd_q         <= bcd_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q + CntOne;
    active_d      = active_q;
    pending_d     = pending_q;
    pend_valid_d  = pend_valid_q;
    an_d          = 8'hFF;
    bcd_d         = 4'hF;
    frame_start_d = 1'b0;
    phase_done    = 1'b0;
    swap          = 1'b0;

    unique case (state_q)
      StBlank: begin
        phase_done = (BLANK_CYCLES == 0) || (cnt_q == BlankLast);
        if (phase_done) begin
          state_d = StShow;
          cnt_d   = '0;
        end
      end
      StShow: begin
        phase_done = (cnt_q == ShowLast);
        if (phase_done) begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
          state_d = (BLANK_CYCLES == 0) ? StShow : StBlank;
          swap    = (idx_q == 3'd7);
        end
      end
      default: begin
        state_d = StBlank;
        idx_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase

    // A load on the swap edge bypasses the pending buffer so it lands in the next frame.
    if (swap) begin
      if (bus.load) begin
        active_d     = bus.digits;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        active_d     = pending_q;
        pend_valid_d = 1'b0;
      end
    end else if (bus.load) begin
      pending_d    = bus.digits;
      pend_valid_d = 1'b1;
    end

    // Outputs are registered, so they are derived from the next state and next buffer.
    shift      = {idx_d, 2'b00};
    digit_nib  = active_d[shift +: 4];
    upper_zero = ((active_d >> shift) == 32'h0);
    suppress   = !bus.en_mask[idx_d] || (bus.lz_blank && (idx_d != 3'd0) && upper_zero);

    if (state_d == StShow) begin
      if (!suppress) begin
        an_d  = ~(8'b1 << idx_d);
        bcd_d = digit_nib;
      end
      frame_start_d = (idx_d == 3'd0) && ((state_q == StBlank) || (idx_q != 3'd0));
    end
  end

  assign bus.an          = an_q;
  assign bus.bcd         = bcd_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomized bench for seg_scan_controller: two parameterizations run in lockstep against
// a frame-position reference model.
module tb_seg_scan_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_controller_if ifa ();
  seg_scan_controller_if ifb ();

  seg_scan_controller #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .CNT_W(3)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  seg_scan_controller #(.REFRESH_DIV(1), .BLANK_CYCLES(0), .CNT_W(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;

  int          mr [2] = '{4, 1};
  int          mb [2] = '{2, 0};
  int          mk [2];
  logic [31:0] m_act  [2];
  logic [31:0] m_pend [2];
  bit          m_pv   [2];
  logic [7:0]  e_an   [2];
  logic [3:0]  e_bcd  [2];
  logic        e_fs   [2];

  logic [31:0] cur_digits = 32'h0;
  logic [7:0]  cur_mask   = 8'hFF;
  logic        cur_lz     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // Position within the frame after edge kk; 0 is the start of digit 0's slot.
  function automatic int qpos(input int d, input int kk);
    if (mb[d] == 0) return (kk - 1) % (8 * mr[d]);
    return kk % (8 * (mr[d] + mb[d]));
  endfunction

  function automatic bit in_show(input int d, input int kk, input int digit);
    int p;
    int q;
    p = mr[d] + mb[d];
    q = qpos(d, kk);
    return (q / p == digit) && (q % p >= mb[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mk[d]     = 0;
      m_act[d]  = 32'h0;
      m_pend[d] = 32'h0;
      m_pv[d]   = 1'b0;
    end
  endtask

  task automatic model_edge(input int d, input bit ld);
    int  p;
    int  q;
    int  digit;
    int  r;
    bit  swap;
    bit  sup;
    mk[d]++;
    p     = mr[d] + mb[d];
    q     = qpos(d, mk[d]);
    digit = q / p;
    r     = q % p;
    swap  = (q == 0) && ((mb[d] != 0) || (mk[d] > 1));
    if (swap) begin
      if (ld) begin
        m_act[d] = cur_digits;
        m_pv[d]  = 1'b0;
      end else if (m_pv[d]) begin
        m_act[d] = m_pend[d];
        m_pv[d]  = 1'b0;
      end
    end else if (ld) begin
      m_pend[d] = cur_digits;
      m_pv[d]   = 1'b1;
    end
    e_an[d]  = 8'hFF;
    e_bcd[d] = 4'hF;
    e_fs[d]  = 1'b0;
    if (r >= mb[d]) begin
      e_fs[d] = (digit == 0) && (r == mb[d]);
      sup = !cur_mask[digit] ||
            (cur_lz && digit != 0 && ((m_act[d] >> (4 * digit)) == 32'h0));
      if (!sup) begin
        e_an[d]  = 8'hFF ^ (8'h01 << digit);
        e_bcd[d] = 4'((m_act[d] >> (4 * digit)) & 32'hF);
      end
    end
  endtask

  task automatic step(input bit ld);
    ifa.digits = cur_digits; ifa.en_mask = cur_mask; ifa.lz_blank = cur_lz; ifa.load = ld;
    ifb.digits = cur_digits; ifb.en_mask = cur_mask; ifb.lz_blank = cur_lz; ifb.load = ld;
    @(posedge clk);
    #1;
    model_edge(0, ld);
    model_edge(1, ld);
    check("a_an",  32'(ifa.an),          32'(e_an[0]));
    check("a_bcd", 32'(ifa.bcd),         32'(e_bcd[0]));
    check("a_fs",  32'(ifa.frame_start), 32'(e_fs[0]));
    check("b_an",  32'(ifb.an),          32'(e_an[1]));
    check("b_bcd", 32'(ifb.bcd),         32'(e_bcd[1]));
    check("b_fs",  32'(ifb.frame_start), 32'(e_fs[1]));
    ifa.load = 1'b0;
    ifb.load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  // Advance until DUT A is showing the given digit.
  task automatic run_until_show(input int digit);
    int guard;
    guard = 0;
    while (!in_show(0, mk[0], digit) && guard < 200) begin
      step(1'b0);
      guard++;
    end
    if (guard >= 200) check("timeout_show", 32'd0, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_a_an"},  32'(ifa.an),          32'hFF);
    check({tag, "_a_bcd"}, 32'(ifa.bcd),         32'hF);
    check({tag, "_a_fs"},  32'(ifa.frame_start), 32'h0);
    check({tag, "_b_an"},  32'(ifb.an),          32'hFF);
    check({tag, "_b_bcd"}, 32'(ifb.bcd),         32'hF);
    check({tag, "_b_fs"},  32'(ifb.frame_start), 32'h0);
  endtask

  initial begin
    int guard;
    ifa.digits = '0; ifa.load = 1'b0; ifa.en_mask = 8'hFF; ifa.lz_blank = 1'b0;
    ifb.digits = '0; ifb.load = 1'b0; ifb.en_mask = 8'hFF; ifb.lz_blank = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #4;
    check_idle("rst");
    rst_n = 1'b1;

    // Scan order with a known pattern.
    cur_digits = 32'h87654321;
    step(1'b1);
    run(110);

    // Load mid-frame, then load exactly on the swap edge.
    run_until_show(2);
    cur_digits = 32'h11111111;
    step(1'b1);
    run(100);
    guard = 0;
    while (qpos(0, mk[0] + 1) != 0 && guard < 100) begin
      step(1'b0);
      guard++;
    end
    if (guard >= 100) check("timeout_swap", 32'd0, 32'd1);
    cur_digits = 32'h22222222;
    step(1'b1);
    run(60);

    // Masking.
    cur_mask = 8'b1010_0101;
    run(100);
    cur_mask = 8'hFF;

    // Leading-zero suppression.
    cur_lz = 1'b1;
    cur_digits = 32'h00000120; step(1'b1); run(100);
    cur_digits = 32'h00000000; step(1'b1); run(100);
    cur_digits = 32'h10000000; step(1'b1); run(100);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit ld;
      ld = ($urandom_range(0, 9) == 0);
      if (ld) cur_digits = $urandom >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 15) == 0) cur_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 31) == 0) cur_lz = ~cur_lz;
      step(ld);
    end

    // Asynchronous reset while DUT A is lit on digit 3.
    cur_mask = 8'hFF;
    cur_lz = 1'b0;
    cur_digits = 32'h98765432;
    step(1'b1);
    run(60);
    run_until_show(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    #2;
    rst_n = 1'b1;
    model_reset();
    run(120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
